bmp_stream_writer: RTL and testbench

BMP_STREAM_WRITER -- requirements
Module: bmp_stream_writer

---
 rtl/bmp_stream_writer.sv | 177 +++++++++++++++++
 tb/tb_bmp_stream_writer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bmp_stream_writer.sv
// Streams one 24-bit uncompressed BMP file per start pulse: a 54-byte header built
// from the parameters, then grayscale FIFO pixels replicated to B,G,R with row padding.
module bmp_stream_writer #(
  parameter int WIDTH  = 720,
  parameter int HEIGHT = 540
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       in_empty,
  input  logic [7:0] in_dout,
  output logic       in_rd_en,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       busy,
  output logic       done
);

  localparam int PAD_BYTES = (4 - ((3 * WIDTH) % 4)) % 4;
  localparam int IMG       = HEIGHT * (3 * WIDTH + PAD_BYTES);
  localparam int CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW        = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [1:0]    PAD_LAST = (PAD_BYTES > 0) ? 2'(PAD_BYTES - 1) : 2'd0;
  localparam logic [5:0]    HDR_LAST = 6'd53;

  typedef enum logic [2:0] {IDLE, HEADER, PIXEL, PAD, DONE} state_t;

  state_t        state, state_n;
  logic [5:0]    hdr_cnt;
  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  logic [1:0]    byte_idx;
  logic [1:0]    pad_cnt;

  logic accept;
  logic last_row;
  logic row_end;
  logic pad_end;

  // Bytes 2..53 form thirteen 32-bit little-endian words; planes and bpp share word 6.
  function automatic logic [7:0] header_byte(input logic [5:0] idx);
    logic [5:0]  rel;
    logic [31:0] word;
    logic [7:0]  b;
    rel = idx - 6'd2;
    case (rel[5:2])
      4'd0:        word = 32'(54 + IMG);
      4'd2:        word = 32'd54;
      4'd3:        word = 32'd40;
      4'd4:        word = 32'(WIDTH);
      4'd5:        word = 32'(HEIGHT);
      4'd6:        word = 32'h0018_0001;
      4'd8:        word = 32'(IMG);
      4'd9, 4'd10: word = 32'd2835;
      default:     word = 32'd0;
    endcase
    if (idx == 6'd0)      b = 8'h42;
    else if (idx == 6'd1) b = 8'h4D;
    else                  b = word[{rel[1:0], 3'b000} +: 8];
    return b;
  endfunction

  assign accept   = out_valid && out_ready;
  assign last_row = (row_cnt == ROW_LAST);
  assign row_end  = (state == PIXEL) && accept && (byte_idx == 2'd2) && (col_cnt == COL_LAST);
  assign pad_end  = (state == PAD) && accept && (pad_cnt == PAD_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:   if (start) state_n = HEADER;
      HEADER: if (accept && (hdr_cnt == HDR_LAST)) state_n = PIXEL;
      PIXEL: begin
        if (row_end) begin
          if (PAD_BYTES > 0) state_n = PAD;
          else if (last_row) state_n = DONE;
          else               state_n = PIXEL;
        end
      end
      PAD:    if (pad_end) state_n = last_row ? DONE : PIXEL;
      DONE:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    out_data  = 8'h00;
    out_last  = 1'b0;
    in_rd_en  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      HEADER: begin
        out_valid = 1'b1;
        out_data  = header_byte(hdr_cnt);
        busy      = 1'b1;
      end
      PIXEL: begin
        out_valid = !in_empty;
        out_data  = in_dout;
        busy      = 1'b1;
        in_rd_en  = !in_empty && out_ready && (byte_idx == 2'd2);
        out_last  = !in_empty && (PAD_BYTES == 0) && last_row &&
                    (col_cnt == COL_LAST) && (byte_idx == 2'd2);
      end
      PAD: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_last  = last_row && (pad_cnt == PAD_LAST);
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Counters move only on accepted bytes; IDLE rearms them for the next frame.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hdr_cnt  <= '0;
      col_cnt  <= '0;
      row_cnt  <= '0;
      byte_idx <= '0;
      pad_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          hdr_cnt  <= '0;
          col_cnt  <= '0;
          row_cnt  <= '0;
          byte_idx <= '0;
          pad_cnt  <= '0;
        end
        HEADER: begin
          if (accept) hdr_cnt <= (hdr_cnt == HDR_LAST) ? 6'd0 : hdr_cnt + 6'd1;
        end
        PIXEL: begin
          if (accept) begin
            if (byte_idx == 2'd2) begin
              byte_idx <= 2'd0;
              if (col_cnt == COL_LAST) begin
                col_cnt <= '0;
                if (PAD_BYTES == 0) row_cnt <= row_cnt + 1'b1;
              end else begin
                col_cnt <= col_cnt + 1'b1;
              end
            end else begin
              byte_idx <= byte_idx + 2'd1;
            end
          end
        end
        PAD: begin
          if (accept) begin
            if (pad_cnt == PAD_LAST) begin
              pad_cnt <= 2'd0;
              row_cnt <= row_cnt + 1'b1;
            end else begin
              pad_cnt <= pad_cnt + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bmp_stream_writer.sv
// Randomized bench for bmp_stream_writer: several parameterizations share one input
// bus; idle instances drive zeros, so their outputs are OR-combined for checking.
module tb_bmp_stream_writer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] start_v = '0;
  logic       in_empty = 1'b1;
  logic [7:0] in_dout = 8'h00;
  logic       out_ready = 1'b0;

  logic [4:0] rd_v, val_v, last_v, busy_v, done_v;
  logic [7:0] data_v [5];

  logic       in_rd_en, out_valid, out_last, busy, done;
  logic [7:0] out_data;

  assign in_rd_en  = |rd_v;
  assign out_valid = |val_v;
  assign out_last  = |last_v;
  assign busy      = |busy_v;
  assign done      = |done_v;
  assign out_data  = data_v[0] | data_v[1] | data_v[2] | data_v[3] | data_v[4];

  always #5 clock = ~clock;

  bmp_stream_writer #(.WIDTH(720), .HEIGHT(540)) u_def (
    .clock(clock), .reset(reset), .start(start_v[0]), .in_empty(in_empty), .in_dout(in_dout),
    .in_rd_en(rd_v[0]), .out_valid(val_v[0]), .out_ready(out_ready), .out_data(data_v[0]),
    .out_last(last_v[0]), .busy(busy_v[0]), .done(done_v[0]));
  bmp_stream_writer #(.WIDTH(2), .HEIGHT(2)) u_2x2 (
    .clock(clock), .reset(reset), .start(start_v[1]), .in_empty(in_empty), .in_dout(in_dout),
    .in_rd_en(rd_v[1]), .out_valid(val_v[1]), .out_ready(out_ready), .out_data(data_v[1]),
    .out_last(last_v[1]), .busy(busy_v[1]), .done(done_v[1]));
  bmp_stream_writer #(.WIDTH(3), .HEIGHT(2)) u_3x2 (
    .clock(clock), .reset(reset), .start(start_v[2]), .in_empty(in_empty), .in_dout(in_dout),
    .in_rd_en(rd_v[2]), .out_valid(val_v[2]), .out_ready(out_ready), .out_data(data_v[2]),
    .out_last(last_v[2]), .busy(busy_v[2]), .done(done_v[2]));
  bmp_stream_writer #(.WIDTH(5), .HEIGHT(3)) u_5x3 (
    .clock(clock), .reset(reset), .start(start_v[3]), .in_empty(in_empty), .in_dout(in_dout),
    .in_rd_en(rd_v[3]), .out_valid(val_v[3]), .out_ready(out_ready), .out_data(data_v[3]),
    .out_last(last_v[3]), .busy(busy_v[3]), .done(done_v[3]));
  bmp_stream_writer #(.WIDTH(4), .HEIGHT(3)) u_4x3 (
    .clock(clock), .reset(reset), .start(start_v[4]), .in_empty(in_empty), .in_dout(in_dout),
    .in_rd_en(rd_v[4]), .out_valid(val_v[4]), .out_ready(out_ready), .out_data(data_v[4]),
    .out_last(last_v[4]), .busy(busy_v[4]), .done(done_v[4]));

  int          total = 0;
  int          bad = 0;
  bit          use_tbl = 1'b0;
  int unsigned seed = 0;
  logic [7:0]  tbl [4] = '{8'hA5, 8'h01, 8'h02, 8'h03};
  logic [7:0]  fifo_q [$];
  int          feed_n = 0;
  logic [7:0]  hdr_cap [54];

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int pad_of(input int w);
    return (4 - ((3 * w) % 4)) % 4;
  endfunction

  function automatic logic [7:0] le(input int v, input int b);
    return 8'(v >> (8 * b));
  endfunction

  function automatic logic [7:0] ref_header(input int k, input int w, input int h);
    int img;
    img = h * (3 * w + pad_of(w));
    if (k == 0) return 8'h42;
    if (k == 1) return 8'h4D;
    if (k < 6)  return le(54 + img, k - 2);
    if (k < 10) return 8'h00;
    if (k < 14) return le(54, k - 10);
    if (k < 18) return le(40, k - 14);
    if (k < 22) return le(w, k - 18);
    if (k < 26) return le(h, k - 22);
    if (k < 28) return le(1, k - 26);
    if (k < 30) return le(24, k - 28);
    if (k < 34) return 8'h00;
    if (k < 38) return le(img, k - 34);
    if (k < 42) return le(2835, k - 38);
    if (k < 46) return le(2835, k - 42);
    return 8'h00;
  endfunction

  function automatic logic [7:0] pix(input int n);
    if (use_tbl) return tbl[n % 4];
    return 8'((n * 73) ^ seed ^ (n >> 5));
  endfunction

  task automatic drive_fifo(input int total_px, input int p_empty);
    while (fifo_q.size() < 4 && feed_n < total_px) begin
      fifo_q.push_back(pix(feed_n));
      feed_n++;
    end
    in_empty = (fifo_q.size() == 0) || ($urandom_range(99) < p_empty);
    in_dout  = (fifo_q.size() != 0) ? fifo_q[0] : 8'($urandom);
  endtask

  // Runs one frame (or its first max_bytes bytes) on instance idx against the model.
  task automatic run_frame(input int idx, input int w, input int h, input int p_ready,
                           input int p_empty, input int max_bytes, input int extra_start);
    int rowlen, nb, k, j, c, pops, dones, cyc, limit;
    bit pop_pend, is_pix, stop;
    logic [7:0] eb;
    rowlen = 3 * w + pad_of(w);
    nb     = 54 + h * rowlen;
    k = 0; pops = 0; dones = 0; cyc = 0; feed_n = 0;
    fifo_q.delete();
    pop_pend = 1'b0;
    stop = 1'b0;
    for (int i = 0; i < 54; i++) hdr_cap[i] = 8'h00;
    limit = ((max_bytes > 0) ? max_bytes : nb) * 8 + 100;
    @(posedge clock); #1;
    start_v[idx] = 1'b1;
    out_ready = 1'b1;
    drive_fifo(w * h, p_empty);
    @(posedge clock); #1;
    start_v[idx] = 1'b0;
    while (!stop) begin
      if (pop_pend) void'(fifo_q.pop_front());
      pop_pend = 1'b0;
      start_v[idx] = (cyc == extra_start);
      out_ready = ($urandom_range(99) < p_ready);
      drive_fifo(w * h, p_empty);
      @(negedge clock);
      if (k == nb) begin
        chk("done_end", done, 1);
        chk("valid_end", out_valid, 0);
        chk("busy_end", busy, 0);
        if (done) dones++;
        stop = 1'b1;
      end else begin
        is_pix = 1'b0;
        c = 0;
        if (k < 54) eb = ref_header(k, w, h);
        else begin
          j = k - 54;
          c = j % rowlen;
          is_pix = (c < 3 * w);
          eb = is_pix ? pix((j / rowlen) * w + c / 3) : 8'h00;
        end
        chk("busy", busy, 1);
        chk("done", done, 0);
        chk("valid", out_valid, is_pix ? !in_empty : 1'b1);
        if (out_valid) begin
          chk("data", out_data, eb);
          chk("last", out_last, (k == nb - 1));
        end
        chk("rd_en", in_rd_en, out_valid && out_ready && is_pix && (c % 3 == 2));
        if (in_rd_en) begin
          pops++;
          pop_pend = 1'b1;
        end
        if (out_valid && out_ready) begin
          if (k < 54) hdr_cap[k] = out_data;
          k++;
        end
        if (max_bytes > 0 && k >= max_bytes) stop = 1'b1;
      end
      cyc++;
      if (!stop && cyc > limit) begin
        chk("timeout_bytes", k, nb);
        stop = 1'b1;
      end
      @(posedge clock); #1;
    end
    if (pop_pend) void'(fifo_q.pop_front());
    start_v[idx] = 1'b0;
    if (max_bytes == 0) begin
      repeat (2) begin
        @(negedge clock);
        if (done) dones++;
      end
      chk("done_cnt", dones, 1);
      chk("pops", pops, w * h);
      chk("idle_valid", out_valid, 0);
      @(posedge clock); #1;
    end
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_rd_en"}, in_rd_en, 0);
    chk({tag, "_last"}, out_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_data"}, out_data, 0);
  endtask

  task automatic do_reset(input bit check);
    out_ready = 1'b1;
    in_empty  = 1'b0;
    in_dout   = 8'hC3;
    #2 reset = 1'b0;
    #1;
    if (check) check_quiet("midrst");
    @(negedge clock);
    if (check) check_quiet("midrst2");
    reset = 1'b1;
    fifo_q.delete();
    feed_n = 0;
  endtask

  int         lit_idx [13] = '{0, 1, 2, 3, 4, 5, 18, 19, 22, 23, 34, 35, 36};
  logic [7:0] lit_val [13] = '{8'h42, 8'h4D, 8'h76, 8'hCC, 8'h11, 8'h00, 8'hD0, 8'h02,
                               8'h1C, 8'h02, 8'h40, 8'hCC, 8'h11};
  int         wt [5] = '{720, 2, 3, 5, 4};
  int         ht [5] = '{540, 2, 2, 3, 3};

  initial begin
    start_v   = 5'h1F;
    out_ready = 1'b1;
    in_empty  = 1'b0;
    in_dout   = 8'h5A;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_quiet("rst");
    start_v = '0;
    reset   = 1'b1;

    // Default geometry: header literals, ignored start while busy, abort by reset.
    use_tbl = 1'b0;
    seed = $urandom;
    run_frame(0, 720, 540, 100, 0, 120, 5);
    for (int i = 0; i < 13; i++) chk($sformatf("hdr%0d", lit_idx[i]), hdr_cap[lit_idx[i]], lit_val[i]);
    do_reset(1'b1);
    run_frame(0, 720, 540, 70, 30, 60, -1);
    chk("restart_b0", hdr_cap[0], 8'h42);
    chk("restart_b1", hdr_cap[1], 8'h4D);
    do_reset(1'b0);

    // 2x2 frame from a fixed pixel table.
    use_tbl = 1'b1;
    run_frame(1, 2, 2, 100, 0, 0, -1);
    chk("size_2x2", hdr_cap[2], 8'h46);
    chk("img_2x2", hdr_cap[34], 8'h10);

    // Random back-pressure and FIFO underflow across all padding cases.
    use_tbl = 1'b0;
    for (int r = 0; r < 12; r++) begin
      int idx;
      idx = 1 + (r % 4);
      seed = $urandom;
      run_frame(idx, wt[idx], ht[idx], (r < 4) ? 100 : 55, (r < 4) ? 0 : 35, 0,
                int'($urandom_range(40)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
